// File: rtl/ch0re_pkg.sv
// Shared types and exception causes for the ch0re load/store unit.
package ch0re_pkg;

  typedef enum logic {
    OpLoad  = 1'b0,
    OpStore = 1'b1
  } lsu_op_e;

  // Low two bits encode log2(access size); bit 2 marks the zero-extending variants.
  typedef enum logic [2:0] {
    DtByte   = 3'd0,
    DtHalf   = 3'd1,
    DtWord   = 3'd2,
    DtDouble = 3'd3,
    DtByteU  = 3'd4,
    DtHalfU  = 3'd5,
    DtWordU  = 3'd6
  } dtype_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  localparam logic [3:0] ExcIllegalDtype  = 4'd2;
  localparam logic [3:0] ExcLoadMisalign  = 4'd4;
  localparam logic [3:0] ExcStoreMisalign = 4'd6;

endpackage

// File: rtl/ch0re_lsu_align.sv
// Byte-lane alignment: stores shift data/enables up to the lane, loads shift the
// word down and sign- or zero-extend it to XLEN.
module ch0re_lsu_align import ch0re_pkg::*; #(
  parameter int unsigned XLEN = 64
) (
  input  logic                       store_i,
  input  dtype_e                     dtype_i,
  input  logic [$clog2(XLEN/8)-1:0]  lane_i,
  input  logic [XLEN-1:0]            data_i,
  output logic [XLEN-1:0]            data_o,
  output logic [XLEN/8-1:0]          be_o
);

  localparam int unsigned NumBytes = XLEN / 8;

  logic [NumBytes-1:0]     size_mask;
  logic [$clog2(XLEN)-1:0] shamt;
  logic [XLEN-1:0]         shifted;

  assign shamt = {lane_i, 3'b000};

  always_comb begin
    unique case (dtype_i[1:0])
      2'd0:    size_mask = NumBytes'(4'h1);
      2'd1:    size_mask = NumBytes'(4'h3);
      2'd2:    size_mask = NumBytes'(4'hF);
      default: size_mask = '1;
    endcase
  end

  // Enables past the top lane fall off the end of the word.
  assign be_o = size_mask << lane_i;

  always_comb begin
    shifted = data_i >> shamt;
    data_o  = shifted;
    if (store_i) begin
      data_o = data_i << shamt;
    end else begin
      case (dtype_i)
        DtByte:  data_o = XLEN'(signed'(shifted[7:0]));
        DtHalf:  data_o = XLEN'(signed'(shifted[15:0]));
        DtWord:  data_o = XLEN'(signed'(shifted[31:0]));
        DtByteU: data_o = XLEN'(shifted[7:0]);
        DtHalfU: data_o = XLEN'(shifted[15:0]);
        DtWordU: data_o = XLEN'(shifted[31:0]);
        default: data_o = shifted;
      endcase
    end
  end

endmodule

// File: rtl/ch0re_lsu.sv
// Single-outstanding load/store unit with req/gnt/rvalid memory handshake.
// Define CH0RE_LSU_MISALIGN_EXC_EN to trap accesses not naturally aligned to their size.
module ch0re_lsu import ch0re_pkg::*; #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  lsu_op_e               i_op,
  input  dtype_e                i_dtype,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [4:0]            i_rd,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [XLEN-1:0]       o_rdata,
  output logic [4:0]            o_rd,
  output logic                  o_exc,
  output logic [3:0]            o_exc_cause,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [XLEN/8-1:0]     o_mem_be,
  output logic [XLEN-1:0]       o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [XLEN-1:0]       i_mem_rdata
);

  localparam int unsigned LaneW = $clog2(XLEN / 8);

  lsu_state_e            state_q, state_d;
  lsu_op_e               op_q;
  dtype_e                dtype_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q, rdata_q;
  logic [4:0]            rd_q;
  logic                  exc_q;
  logic [3:0]            cause_q;
  logic                  kill_q, kill_d;

  logic                  accept;
  logic                  illegal, misalign, acc_exc;
  logic [3:0]            acc_cause;
  logic [LaneW-1:0]      lane;
  logic [XLEN-1:0]       st_data, ld_data;
  logic [XLEN/8-1:0]     st_be, ld_be_unused;

  assign accept  = i_valid && (state_q == StIdle);
  assign illegal = (i_dtype > DtWordU) || ((XLEN == 32) && (i_dtype == DtDouble));

`ifdef CH0RE_LSU_MISALIGN_EXC_EN
  logic [LaneW-1:0] align_mask;

  always_comb begin
    unique case (i_dtype[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = LaneW'(1);
      2'd2:    align_mask = LaneW'(3);
      default: align_mask = '1;
    endcase
  end

  assign misalign = |(i_addr[LaneW-1:0] & align_mask);
`else
  assign misalign = 1'b0;
`endif

  assign acc_exc   = illegal || misalign;
  assign acc_cause = illegal ? ExcIllegalDtype :
                     (i_op == OpStore) ? ExcStoreMisalign : ExcLoadMisalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // kill_q marks an access whose response must be swallowed after a flush.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d = acc_exc ? StResp : StReq;
          kill_d  = 1'b0;
        end
      end
      StReq: begin
        if (i_mem_gnt) begin
          if (op_q == OpStore) begin
            state_d = i_flush ? StIdle : StResp;
          end else begin
            state_d = StWait;
            kill_d  = i_flush;
          end
        end else if (i_flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        kill_d = kill_q || i_flush;
        if (i_mem_rvalid) begin
          state_d = (kill_q || i_flush) ? StIdle : StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_mem_req = 1'b0;
    o_exc     = 1'b0;
    unique case (state_q)
      StIdle: o_ready = rst_n;
      StReq:  o_mem_req = 1'b1;
      StResp: begin
        o_valid = 1'b1;
        o_exc   = exc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OpLoad;
      dtype_q <= DtByte;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= i_op;
        dtype_q <= i_dtype;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        rd_q    <= i_rd;
        exc_q   <= acc_exc;
        cause_q <= acc_exc ? acc_cause : 4'd0;
      end
      if ((state_q == StWait) && i_mem_rvalid) begin
        rdata_q <= i_mem_rdata;
      end
    end
  end

  assign lane = addr_q[LaneW-1:0];

  ch0re_lsu_align #(.XLEN(XLEN)) u_st_align (
    .store_i (1'b1),
    .dtype_i (dtype_q),
    .lane_i  (lane),
    .data_i  (wdata_q),
    .data_o  (st_data),
    .be_o    (st_be)
  );

  ch0re_lsu_align #(.XLEN(XLEN)) u_ld_align (
    .store_i (1'b0),
    .dtype_i (dtype_q),
    .lane_i  (lane),
    .data_i  (rdata_q),
    .data_o  (ld_data),
    .be_o    (ld_be_unused)
  );

  assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:LaneW], LaneW'(0)};
  assign o_mem_be    = (op_q == OpStore) ? st_be : '0;
  assign o_mem_wdata = st_data;
  assign o_rdata     = ((op_q == OpLoad) && !exc_q) ? ld_data : '0;
  assign o_rd        = rd_q;
  assign o_exc_cause = cause_q;

endmodule

// File: tb/tb_ch0re_lsu.sv
// Bench for ch0re_lsu: vector table with response scoreboard, plus flush/reset/XLEN=32 cases.
// Expectations follow CH0RE_LSU_MISALIGN_EXC_EN when it is defined.
module tb_ch0re_lsu;
  import ch0re_pkg::*;

  typedef struct {
    lsu_op_e     op;
    dtype_e      dt;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrd;
    int          gd;
    logic [63:0] eaddr;
    logic [7:0]  ebe;
    logic [63:0] ewd;
    logic [63:0] erd;
    logic        exc;
    logic [3:0]  cause;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        exc;
    logic [3:0]  cause;
    logic [4:0]  rd;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_valid, o_ready, i_flush, o_valid, o_exc, o_mem_req;
  logic        i_mem_gnt, i_mem_rvalid;
  lsu_op_e     i_op;
  dtype_e      i_dtype;
  logic [63:0] i_addr, i_wdata, o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [4:0]  i_rd, o_rd;
  logic [3:0]  o_exc_cause;
  logic [7:0]  o_mem_be;

  logic        v32, rdy32, flush32, valid32, exc32, req32, gnt32, rvalid32;
  lsu_op_e     op32;
  dtype_e      dt32;
  logic [31:0] addr32, wdata32, rdata32, maddr32, mwdata32, mrdata32;
  logic [4:0]  rd32, rdo32;
  logic [3:0]  cause32, be32;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_valid = 0;
  resp_t sb_q[$];
  resp_t exp_r;
  vec_t  vecs[12];

  ch0re_lsu #(.XLEN(64), .ADDR_WIDTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_dtype(i_dtype), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .i_flush(i_flush),
    .o_valid(o_valid), .o_rdata(o_rdata), .o_rd(o_rd), .o_exc(o_exc),
    .o_exc_cause(o_exc_cause), .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  ch0re_lsu #(.XLEN(32), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_valid(v32), .o_ready(rdy32), .i_op(op32),
    .i_dtype(dt32), .i_addr(addr32), .i_wdata(wdata32), .i_rd(rd32), .i_flush(flush32),
    .o_valid(valid32), .o_rdata(rdata32), .o_rd(rdo32), .o_exc(exc32),
    .o_exc_cause(cause32), .o_mem_req(req32), .i_mem_gnt(gnt32),
    .o_mem_addr(maddr32), .o_mem_be(be32), .o_mem_wdata(mwdata32),
    .i_mem_rvalid(rvalid32), .i_mem_rdata(mrdata32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(lsu_op_e op, dtype_e dt, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] mrd, int gd, logic [63:0] eaddr, logic [7:0] ebe,
                              logic [63:0] ewd, logic [63:0] erd, logic exc,
                              logic [3:0] cause);
    vec_t v;
    v.op = op; v.dt = dt; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.gd = gd;
    v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd; v.erd = erd; v.exc = exc; v.cause = cause;
    return v;
  endfunction

  // Scoreboard: every completion pops the oldest expected response.
  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", o_valid, 1'b0);
      end else begin
        exp_r = sb_q.pop_front();
        check("resp_rdata", o_rdata, exp_r.rdata);
        check("resp_exc", o_exc, exp_r.exc);
        check("resp_cause", o_exc_cause, exp_r.cause);
        check("resp_rd", o_rd, exp_r.rd);
      end
    end
  end

  task automatic issue(input lsu_op_e op, input dtype_e dt, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd);
    i_valid = 1'b1; i_op = op; i_dtype = dt; i_addr = addr; i_wdata = wdata; i_rd = rd;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] tag, input string p);
    int w = 0;
    while (!o_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({p, "_ready"}, o_ready, 1'b1);
    sb_q.push_back('{rdata: v.erd, exc: v.exc, cause: v.cause, rd: tag});
    issue(v.op, v.dt, v.addr, v.wdata, tag);
    if (!v.exc) begin
      for (int c = 0; c <= v.gd; c++) begin
        check({p, "_req"}, o_mem_req, 1'b1);
        check({p, "_addr"}, o_mem_addr, v.eaddr);
        check({p, "_be"}, o_mem_be, v.ebe);
        check({p, "_wdata"}, o_mem_wdata, v.ewd);
        i_mem_gnt = (c == v.gd);
        @(negedge clk);
      end
      i_mem_gnt = 1'b0;
      if (v.op == OpLoad) begin
        check({p, "_wait_noreq"}, o_mem_req, 1'b0);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = v.mrd;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
      end
    end else begin
      check({p, "_exc_noreq"}, o_mem_req, 1'b0);
    end
    check({p, "_latency"}, o_valid, 1'b1);
    @(negedge clk);
    check({p, "_pulse"}, o_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    rst_n = 1'b0; i_valid = 1'b0; i_op = OpLoad; i_dtype = DtByte; i_addr = '0;
    i_wdata = '0; i_rd = '0; i_flush = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    v32 = 1'b0; op32 = OpLoad; dt32 = DtByte; addr32 = '0; wdata32 = '0; rd32 = '0;
    flush32 = 1'b0; gnt32 = 1'b0; rvalid32 = 1'b0; mrdata32 = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", o_ready, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_req", o_mem_req, 1'b0);
    check("rst_be", o_mem_be, 8'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", o_ready, 1'b1);

    vecs[0]  = mk(OpStore, DtByte, 64'h1003, 64'hAB, 64'h0, 0,
                  64'h1000, 8'h08, 64'hAB00_0000, 64'h0, 1'b0, 4'd0);
    vecs[1]  = mk(OpLoad, DtByte, 64'h5, 64'h0, 64'h0000_8000_0000_0000, 0,
                  64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 4'd0);
    vecs[2]  = mk(OpLoad, DtByteU, 64'h5, 64'h0, 64'h0000_8000_0000_0000, 0,
                  64'h0, 8'h00, 64'h0, 64'h80, 1'b0, 4'd0);
    vecs[3]  = mk(OpLoad, DtWord, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 5,
                  64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 4'd0);
`ifdef CH0RE_LSU_MISALIGN_EXC_EN
    vecs[4]  = mk(OpLoad, DtHalf, 64'h3, 64'h0, 64'h0000_00AB_CD00_0000, 0,
                  64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 4'd4);
    vecs[5]  = mk(OpStore, DtWord, 64'h6, 64'h1122_3344, 64'h0, 1,
                  64'h0, 8'hC0, 64'h3344_0000_0000_0000, 64'h0, 1'b1, 4'd6);
`else
    vecs[4]  = mk(OpLoad, DtHalf, 64'h3, 64'h0, 64'h0000_00AB_CD00_0000, 0,
                  64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 4'd0);
    vecs[5]  = mk(OpStore, DtWord, 64'h6, 64'h1122_3344, 64'h0, 1,
                  64'h0, 8'hC0, 64'h3344_0000_0000_0000, 64'h0, 1'b0, 4'd0);
`endif
    vecs[6]  = mk(OpStore, DtDouble, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0,
                  64'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 4'd0);
    vecs[7]  = mk(OpLoad, DtDouble, 64'h8, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0,
                  64'h8, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 4'd0);
    vecs[8]  = mk(OpLoad, DtHalfU, 64'h2, 64'h0, 64'h0000_0000_8001_0000, 0,
                  64'h0, 8'h00, 64'h0, 64'h8001, 1'b0, 4'd0);
    vecs[9]  = mk(OpLoad, DtWordU, 64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 0,
                  64'h0, 8'h00, 64'h0, 64'h9ABC_DEF0, 1'b0, 4'd0);
    vecs[10] = mk(OpLoad, dtype_e'(3'd7), 64'h0, 64'h0, 64'h0, 0,
                  64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 4'd2);
    vecs[11] = mk(OpStore, DtHalf, 64'h2, 64'hBEEF, 64'h0, 2,
                  64'h0, 8'h0C, 64'hBEEF_0000, 64'h0, 1'b0, 4'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 5'(i + 1), $sformatf("v%0d", i));
    end

    // Flush in the second REQ cycle without a grant.
    nv = n_valid;
    issue(OpLoad, DtWord, 64'h40, 64'h0, 5'd20);
    check("flq_req1", o_mem_req, 1'b1);
    @(negedge clk);
    check("flq_req2", o_mem_req, 1'b1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flq_req_drop", o_mem_req, 1'b0);
    check("flq_ready", o_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("flq_no_valid", n_valid, nv);

    // Flush while waiting for read data.
    issue(OpLoad, DtWord, 64'h40, 64'h0, 5'd21);
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    i_flush   = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flw_still_busy", o_ready, 1'b0);
    @(negedge clk);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'h5555_6666_7777_8888;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    check("flw_valid", o_valid, 1'b0);
    check("flw_ready", o_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("flw_no_valid", n_valid, nv);

    // Asynchronous reset in WAIT, then a stray rvalid.
    issue(OpLoad, DtWord, 64'h1C, 64'hFFFF_0000_FFFF_0000, 5'd9);
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rw_ready", o_ready, 1'b0);
    check("rw_valid", o_valid, 1'b0);
    check("rw_req", o_mem_req, 1'b0);
    check("rw_be", o_mem_be, 8'h0);
    check("rw_exc", o_exc, 1'b0);
    check("rw_rdata", o_rdata, 64'h0);
    check("rw_rd", o_rd, 5'd0);
    check("rw_cause", o_exc_cause, 4'd0);
    check("rw_addr", o_mem_addr, 64'h0);
    check("rw_wdata", o_mem_wdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rw_ready_after", o_ready, 1'b1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    check("stray_valid", o_valid, 1'b0);
    check("stray_rdata", o_rdata, 64'h0);
    check("stray_ready", o_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("rw_no_valid", n_valid, nv);

    // XLEN=32: DOUBLE is an illegal dtype.
    v32 = 1'b1; op32 = OpLoad; dt32 = DtDouble; addr32 = 32'h8; rd32 = 5'd3;
    @(negedge clk);
    v32 = 1'b0;
    check("x32_valid", valid32, 1'b1);
    check("x32_exc", exc32, 1'b1);
    check("x32_cause", cause32, 4'd2);
    check("x32_noreq", req32, 1'b0);
    check("x32_rd", rdo32, 5'd3);
    @(negedge clk);
    check("x32_pulse", valid32, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ch0re_lsu.md
CH0RE_LSU -- requirements
Module: ch0re_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- XLEN, 64, data width; legal values 32 or 64.
- ADDR_WIDTH, 64, byte-address width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- i_valid, in, 1, request valid.
- o_ready, out, 1, request accepted when i_valid and o_ready are both 1.
- i_op, in, 1, 0=load, 1=store (lsu_op_e).
- i_dtype, in, 3, BYTE/HALF/WORD/DOUBLE/BYTEU/HALFU/WORDU (dtype_e).
- i_addr, in, ADDR_WIDTH, byte address.
- i_wdata, in, XLEN, store data, right-aligned.
- i_rd, in, 5, destination register tag.
- i_flush, in, 1, abort the outstanding access.
- o_valid, out, 1, one-cycle completion pulse.
- o_rdata, out, XLEN, extended load data.
- o_rd, out, 5, tag echo.
- o_exc, out, 1, exception on completion.
- o_exc_cause, out, 4, cause code.
- o_mem_req, out, 1, memory request.
- i_mem_gnt, in, 1, request granted.
- o_mem_addr, out, ADDR_WIDTH, word-aligned address.
- o_mem_be, out, XLEN/8, byte enables; all 0 for loads.
- o_mem_wdata, out, XLEN, lane-shifted store data.
- i_mem_rvalid, in, 1, read data valid.
- i_mem_rdata, in, XLEN, read word.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP; o_ready SHALL be 1 only in IDLE.
REQ-005 On acceptance, the block SHALL register op, dtype, addr, wdata and rd, and go to REQ next cycle; DOUBLE with XLEN=32 SHALL be an illegal dtype.
REQ-006 In REQ, o_mem_req SHALL be held at 1 with stable addr, be and wdata until i_mem_gnt is 1.
- Store grant: go to RESP.
- Load grant: go to WAIT.
REQ-007 In WAIT, the block SHALL capture i_mem_rdata on i_mem_rvalid and go to RESP; i_mem_rvalid outside WAIT SHALL be ignored.
REQ-008 In RESP, o_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- Minimum latency, store: 3 cycles acceptance-to-o_valid (gnt in first REQ cycle).
- Minimum latency, load: 4 cycles (gnt and rvalid one cycle apart).
REQ-009 Byte lane SHALL be addr[log2(XLEN/8)-1:0].
- o_mem_be = size mask shifted left by lane.
- o_mem_wdata = i_wdata shifted left by 8*lane.
REQ-010 Loads SHALL shift the captured word right by 8*lane, then sign-extend (BYTE/HALF/WORD) or zero-extend (U types) to XLEN; DOUBLE SHALL pass through.
REQ-011 For stores, o_rdata SHALL be 0.
REQ-012 i_flush SHALL have the following effect by state:
- IDLE or RESP: no effect.
- REQ before grant: drop o_mem_req next cycle, return to IDLE, no o_valid.
- REQ with gnt in the same cycle, or WAIT: the block SHALL wait for rvalid (loads), discard the data and suppress o_valid.
REQ-013 An illegal dtype SHALL skip memory, go directly to RESP and complete with o_exc=1 and cause 2.

Reset
REQ-014 Asserting rst_n low SHALL immediately return the FSM to IDLE.
- Outputs forced: o_ready=0, o_valid=0, o_mem_req=0, o_mem_be=0, o_exc=0.
- Outputs cleared: o_rdata, o_rd, o_exc_cause, o_mem_addr and o_mem_wdata = 0.
REQ-015 o_ready SHALL become 1 in the first cycle after rst_n deasserts; reset mid-access SHALL abandon the access with no completion.

Configuration
REQ-016 With CH0RE_LSU_MISALIGN_EXC_EN defined, an access with addr not naturally aligned to its size SHALL issue no memory request.
- It SHALL complete via RESP with o_exc=1 and o_exc_cause=4 (load) or 6 (store).
REQ-017 Without CH0RE_LSU_MISALIGN_EXC_EN, no alignment check SHALL be performed.
- Lane is computed from the address; bytes past the word boundary are dropped from be and data.
- o_exc SHALL be 1 only for an illegal dtype.

Structure
REQ-018 lsu_op_e, dtype_e and the exception cause constants SHALL reside in the shared package ch0re_pkg.
REQ-019 Lane shift and extension SHALL be a combinational sub-module ch0re_lsu_align, instantiated once for the store path and once for the load path.

Verification
REQ-020 The bench SHALL cover these directed scenarios (XLEN=64 unless stated):
- SB addr=0x1003 data=0xAB, gnt at once -> o_mem_be=0x08, o_mem_wdata=0xAB000000, o_mem_addr=0x1000, o_valid 3 cycles after acceptance.
- LB addr=0x5, rdata=0x0000_8000_0000_0000 -> o_rdata=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- LW addr=0x4, rdata=0x8765_4321_0000_0000 -> o_rdata=0xFFFF_FFFF_8765_4321; gnt delayed 5 cycles -> o_mem_req held 6 cycles, stable.
- LH addr=0x3 with macro -> o_exc=1, cause=4, o_mem_req never 1; without macro -> o_mem_be=0 (load), no exception.
- i_flush in 2nd REQ cycle without gnt -> o_mem_req low next cycle, no o_valid, o_ready=1 following cycle; flush in WAIT -> no o_valid after rvalid.
- rst_n low during WAIT -> all outputs 0 at once; a later stray rvalid is ignored; XLEN=32 LD -> o_exc=1, cause=2.
